// File: rtl/lcd_command_receiver.sv
`default_nettype none
// ============================================================================
// Module  : lcd_command_receiver
// Brief   : HD44780-style LCD command receiver with a 32-byte DDRAM, busy flag and error pulse.
// Revision: 1.0 - initial release
// ============================================================================
module lcd_command_receiver #(
    parameter int BUSY_CMD   = 4000,
    parameter int BUSY_CLEAR = 9000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       RS,
    input  logic       RW,
    input  logic [7:0] Dados,
    output logic [7:0] DadosSaida,
    output logic       Ocupado,
    output logic [4:0] Endereco,
    output logic       DisplayOn,
    output logic       Cursor,
    output logic       Blink,
    output logic       Incremento,
    output logic       Shift,
    output logic       Configurado,
    output logic       Erro,
    input  logic [4:0] RdAddr,
    output logic [7:0] RdData
);

    localparam int BUSY_MAX = (BUSY_CLEAR > BUSY_CMD) ? BUSY_CLEAR : BUSY_CMD;
    localparam int CNT_W    = $clog2(BUSY_MAX + 1);
    localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(BUSY_CMD - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(BUSY_CLEAR - 1);

    typedef enum logic [1:0] {
        UNINIT   = 2'd0,
        IDLE     = 2'd1,
        CLEARING = 2'd2,
        BUSY     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       clr_idx_q, clr_idx_d;
    logic             en_meta_q, en_meta_d, en_sync_q, en_sync_d, en_prev_q, en_prev_d;
    logic             pend_q, pend_d, pend_rs_q, pend_rs_d, pend_rw_q, pend_rw_d;
    logic [7:0]       pend_data_q, pend_data_d;
    logic [4:0]       addr_q, addr_d;
    logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic             inc_q, inc_d, shift_q, shift_d, cfg_q, cfg_d, erro_q, erro_d;
    logic [7:0]       mem_q [0:31];
    logic [7:0]       mem_d [0:31];
    logic             w_fall, w_status, w_fset;

    assign w_fall   = en_prev_q & ~en_sync_q;
    assign w_status = ~pend_rs_q & pend_rw_q;
    assign w_fset   = ~pend_rs_q & ~pend_rw_q & (pend_data_q[7:5] == 3'b001);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_idx_d   = clr_idx_q;
        en_meta_d   = Enable;
        en_sync_d   = en_meta_q;
        en_prev_d   = en_sync_q;
        pend_d      = w_fall;
        pend_rs_d   = w_fall ? RS : pend_rs_q;
        pend_rw_d   = w_fall ? RW : pend_rw_q;
        pend_data_d = w_fall ? Dados : pend_data_q;
        addr_d      = addr_q;
        disp_d      = disp_q;
        cur_d       = cur_q;
        blink_d     = blink_q;
        inc_d       = inc_q;
        shift_d     = shift_q;
        cfg_d       = cfg_q;
        erro_d      = 1'b0;
        mem_d       = mem_q;

        case (state_q)
            BUSY: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            CLEARING: begin
                // Fill runs for the first 32 cycles; the busy window is never shorter.
                if (!clr_idx_q[5]) begin
                    mem_d[clr_idx_q[4:0]] = 8'h20;
                    clr_idx_d             = clr_idx_q + 6'd1;
                end
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    addr_d  = 5'd0;
                    inc_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase

        if (pend_q && !w_status) begin
            if (state_q == IDLE) begin
                state_d = BUSY;
                cnt_d   = CMD_LOAD;
                if (pend_rs_q) begin
                    if (pend_rw_q) begin
                        state_d = IDLE;
                        erro_d  = 1'b1;
                    end else begin
                        mem_d[addr_q] = pend_data_q;
                        addr_d        = inc_q ? addr_q + 5'd1 : addr_q - 5'd1;
                    end
                end else begin
                    casez (pend_data_q)
                        8'b1???????: addr_d = pend_data_q[4:0];
                        8'b001?????: cfg_d  = 1'b1;
                        8'b00001???: begin
                            disp_d  = pend_data_q[2];
                            cur_d   = pend_data_q[1];
                            blink_d = pend_data_q[0];
                        end
                        8'b000001??: begin
                            inc_d   = pend_data_q[1];
                            shift_d = pend_data_q[0];
                        end
                        8'b0000001?: addr_d = 5'd0;
                        8'b00000001: begin
                            state_d   = CLEARING;
                            cnt_d     = CLEAR_LOAD;
                            clr_idx_d = 6'd0;
                        end
                        default: ;
                    endcase
                end
            end else if (state_q == UNINIT && w_fset) begin
                cfg_d   = 1'b1;
                state_d = BUSY;
                cnt_d   = CMD_LOAD;
            end else begin
                erro_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= UNINIT;
            cnt_q       <= '0;
            clr_idx_q   <= 6'd0;
            en_meta_q   <= 1'b0;
            en_sync_q   <= 1'b0;
            en_prev_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_rs_q   <= 1'b0;
            pend_rw_q   <= 1'b0;
            pend_data_q <= 8'h00;
            addr_q      <= 5'd0;
            disp_q      <= 1'b0;
            cur_q       <= 1'b0;
            blink_q     <= 1'b0;
            inc_q       <= 1'b1;
            shift_q     <= 1'b0;
            cfg_q       <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_idx_q   <= clr_idx_d;
            en_meta_q   <= en_meta_d;
            en_sync_q   <= en_sync_d;
            en_prev_q   <= en_prev_d;
            pend_q      <= pend_d;
            pend_rs_q   <= pend_rs_d;
            pend_rw_q   <= pend_rw_d;
            pend_data_q <= pend_data_d;
            addr_q      <= addr_d;
            disp_q      <= disp_d;
            cur_q       <= cur_d;
            blink_q     <= blink_d;
            inc_q       <= inc_d;
            shift_q     <= shift_d;
            cfg_q       <= cfg_d;
            erro_q      <= erro_d;
        end
    end

    // DDRAM keeps its contents across reset; writes stop because the FSM sits in UNINIT.
    always_ff @(posedge Clock) begin
        mem_q <= mem_d;
    end

    assign Ocupado     = (state_q == BUSY) || (state_q == CLEARING);
    assign Endereco    = addr_q;
    assign DadosSaida  = {Ocupado, 2'b00, addr_q};
    assign DisplayOn   = disp_q;
    assign Cursor      = cur_q;
    assign Blink       = blink_q;
    assign Incremento  = inc_q;
    assign Shift       = shift_q;
    assign Configurado = cfg_q;
    assign Erro        = erro_q;
    assign RdData      = mem_q[RdAddr];

endmodule
`default_nettype wire

// File: doc/lcd_command_receiver.md
LCD_COMMAND_RECEIVER -- requirements
Module: lcd_command_receiver

Parameters
REQ-001 SHALL have parameter BUSY_CMD, default 4000: busy duration in Clock cycles for every accepted instruction except Clear Display.
REQ-002 SHALL have parameter BUSY_CLEAR, default 9000000: busy duration in Clock cycles for Clear Display; SHALL be at least 32.

Interface
REQ-003 SHALL have input Clock, 1 bit: system clock; all state changes on its rising edge.
REQ-004 SHALL have input Reset, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have input Enable, 1 bit: LCD E strobe from the driver; asynchronous to Clock.
REQ-006 SHALL have inputs RS and RW, 1 bit each: register select and read/write select.
REQ-007 SHALL have input Dados, 8 bits: instruction or data byte from the driver.
REQ-008 SHALL have output DadosSaida, 8 bits: status word {Ocupado, 2'b00, Endereco}.
REQ-009 SHALL have output Ocupado, 1 bit: busy flag.
REQ-010 SHALL have output Endereco, 5 bits: DDRAM address counter.
REQ-011 SHALL have outputs DisplayOn, Cursor, Blink, Incremento, Shift, 1 bit each: latched mode bits.
REQ-012 SHALL have output Configurado, 1 bit: high once Function Set has been accepted.
REQ-013 SHALL have output Erro, 1 bit: one-cycle pulse for each rejected strobe.
REQ-014 SHALL have input RdAddr, 5 bits, and output RdData, 8 bits: combinational DDRAM readout port.

Function
REQ-015 SHALL synchronize Enable through two flops and detect the falling edge (1 to 0) on the synchronized signal; RS, RW and Dados SHALL be sampled in the detect cycle N.
REQ-016 SHALL execute the sampled strobe in cycle N+1 only when the FSM is in IDLE.
REQ-017 SHALL implement FSM states UNINIT, IDLE, CLEARING, BUSY.
- UNINIT->IDLE: on Function Set (RS=0, RW=0, Dados[7:5]=001).
- IDLE->BUSY: on any other accepted write.
- IDLE->CLEARING: on Clear Display.
- BUSY->IDLE and CLEARING->IDLE: when the busy counter reaches 0.
REQ-018 In UNINIT, any strobe other than Function Set or a status read SHALL pulse Erro and be ignored.
REQ-019 A write strobe in BUSY or CLEARING SHALL pulse Erro and be ignored; no state, memory or address change.
REQ-020 A status read (RS=0, RW=1) SHALL never raise Erro and SHALL never change state; DadosSaida is valid at all times.
REQ-021 An accepted instruction SHALL assert Ocupado from cycle N+1 for exactly BUSY_CMD cycles (BUSY_CLEAR for Clear Display); Function Set SHALL also make the module busy for BUSY_CMD cycles.
REQ-022 Instruction decode (RS=0, RW=0), highest set bit wins:
- 1aaaaaaa: Set DDRAM Address, Endereco=a[4:0], bits 6:5 ignored.
- 001xxxxx: Function Set, Configurado=1.
- 00001DCB: DisplayOn=D, Cursor=C, Blink=B.
- 000001IS: Incremento=I, Shift=S.
- 0000001x: Return Home, Endereco=0.
- 00000001: Clear Display.
- 00000000: no-op; still makes the module busy for BUSY_CMD cycles.
REQ-023 Clear Display SHALL write 8'h20 to all 32 DDRAM entries, one per cycle, during CLEARING, then set Endereco=0 and Incremento=1.
REQ-024 Data write (RS=1, RW=0) SHALL store Dados at mem[Endereco], then step Endereco by +1 if Incremento=1, else -1, modulo 32 (31+1=0, 0-1=31).
REQ-025 Data read (RS=1, RW=1) SHALL pulse Erro and be ignored.
REQ-026 Strobes arriving while a previous strobe awaits execution SHALL NOT queue; only the detect-cycle sample matters.

Reset
REQ-027 Reset low SHALL immediately force:
- FSM to UNINIT, busy counter to 0;
- Ocupado=0, Endereco=0, DisplayOn=0, Cursor=0, Blink=0, Incremento=1, Shift=0, Configurado=0, Erro=0;
- synchronizer flops to 0.
REQ-028 DDRAM contents SHALL NOT be reset; a reset mid-CLEARING SHALL abort the clear.

Verification (BUSY_CMD=4, BUSY_CLEAR=40)
REQ-029 Write Dados=0x38 (Function Set) -> Configurado=1, Ocupado high for exactly 4 cycles, FSM ends in IDLE.
REQ-030 Before Function Set, write Dados=0x0F -> Erro pulses once, DisplayOn stays 0.
REQ-031 Init sequence 0x38, 0x0D, 0x01, 0x06 each after Ocupado falls -> DisplayOn=1, Cursor=0, Blink=1, all RdData=0x20, Endereco=0.
REQ-032 Set address 0x9F, write data 0x41 -> mem[31]=0x41 and Endereco=0; with Incremento=0, a write at address 0 -> Endereco=31.
REQ-033 Write command while Ocupado=1 -> Erro pulse, no change; status read during busy -> DadosSaida[7]=1.
REQ-034 Assert Reset at cycle 10 of CLEARING -> outputs at reset values, FSM in UNINIT, remaining entries keep their old values.
